// File: rtl/barrel_pkg.sv
// Shared types and encodings for the barrel shift/rotate datapath.
// Used by the forward shifter bench and by the unshifter.
package barrel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_SHIFT  = 1'b0;
    localparam logic OP_ROTATE = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/barrel_unshifter_seq_if.sv
// Request/response bus of the unshifter.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both high.
interface barrel_unshifter_seq_if #(
    parameter int WIDTH = 4
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic             select;
    logic             direction;
    logic [SHW-1:0]   shift_value;
    logic [WIDTH-1:0] din;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             exact;

    modport master (
        output in_valid, select, direction, shift_value, din, out_ready,
        input  in_ready, out_valid, dout, exact
    );

    modport slave (
        input  in_valid, select, direction, shift_value, din, out_ready,
        output in_ready, out_valid, dout, exact
    );

endinterface

// File: rtl/barrel_step.sv
// One-bit shift or rotate of a word, left or right.
// Reports the bit that leaves the word so the caller can detect lost data.
module barrel_step
    import barrel_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic             select_i,
    input  logic             step_left_i,
    output logic [WIDTH-1:0] word_o,
    output logic             out_bit_o
);

    logic fill;

    always_comb begin
        word_o    = '0;
        out_bit_o = 1'b0;
        fill      = 1'b0;
        if (step_left_i) begin
            out_bit_o = word_i[WIDTH-1];
            fill      = (select_i == OP_ROTATE) ? word_i[WIDTH-1] : 1'b0;
            word_o    = {word_i[WIDTH-2:0], fill};
        end else begin
            out_bit_o = word_i[0];
            fill      = (select_i == OP_ROTATE) ? word_i[0] : 1'b0;
            word_o    = {fill, word_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/barrel_unshifter_seq.sv
// Iterative inverse of the barrel shifter: undoes one bit position per clock,
// flagging shifts whose forward pass must have dropped nonzero bits.
module barrel_unshifter_seq
    import barrel_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    barrel_unshifter_seq_if.slave bus,
    output state_t                dbg_state_o
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [SHW-1:0]   cnt_q;
    logic             exact_q;
    logic             sel_q;
    logic             dir_q;
    logic             lost_bit;

    // Undo the forward motion: a forward right shift is reversed by stepping left.
    barrel_step #(.WIDTH(WIDTH)) u_step (
        .word_i      (work_q),
        .select_i    (sel_q),
        .step_left_i (dir_q == DIR_RIGHT),
        .word_o      (work_d),
        .out_bit_o   (lost_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            exact_q <= 1'b0;
            sel_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q  <= bus.din;
                        cnt_q   <= bus.shift_value;
                        exact_q <= 1'b1;
                        sel_q   <= bus.select;
                        dir_q   <= bus.direction;
                        state_q <= (bus.shift_value == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    // Rotates never lose bits; a shifted-out 1 in shift mode is sticky.
                    if (sel_q == OP_SHIFT && lost_bit) begin
                        exact_q <= 1'b0;
                    end
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.dout      = work_q;
    assign bus.exact     = exact_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_barrel_unshifter_seq.sv
// Directed plus random bench for barrel_unshifter_seq with a scoreboard queue of {dout, exact}.
module tb_barrel_unshifter_seq;
    import barrel_pkg::*;

    localparam int WIDTH   = 4;
    localparam int SHW     = $clog2(WIDTH);
    localparam int TIMEOUT = 20;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] exp_q[$];

    barrel_unshifter_seq_if #(.WIDTH(WIDTH)) bus ();

    barrel_unshifter_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: inverse computed as a whole-word operation, not bit by bit.
    function automatic logic [WIDTH:0] model(input logic sel, input logic dir,
                                             input logic [SHW-1:0] sv, input logic [WIDTH-1:0] d);
        logic [2*WIDTH-1:0] dd;
        logic [WIDTH-1:0]   r;
        logic [WIDTH-1:0]   mask;
        logic               ex;
        if (sel) begin
            if (!dir) begin
                dd = {d, d} << sv;
                r  = dd[2*WIDTH-1:WIDTH];
            end else begin
                dd = {d, d} >> sv;
                r  = dd[WIDTH-1:0];
            end
            ex = 1'b1;
        end else if (!dir) begin
            r  = d << sv;
            ex = ((d >> (WIDTH - int'(sv))) == '0);
        end else begin
            r    = d >> sv;
            mask = WIDTH'((1 << sv) - 1);
            ex   = ((d & mask) == '0);
        end
        return {r, ex};
    endfunction

    task automatic do_op(input string tag, input logic sel, input logic dir,
                         input logic [SHW-1:0] sv, input logic [WIDTH-1:0] d,
                         input logic [WIDTH:0] expected, input int hold);
        int             lat;
        logic [WIDTH:0] exp_v;
        check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
        bus.select      = sel;
        bus.direction   = dir;
        bus.shift_value = sv;
        bus.din         = d;
        bus.in_valid    = 1'b1;
        exp_q.push_back(expected);
        @(posedge clk); #1;
        lat = 1;
        // Keep presenting garbage while busy: it must be neither accepted nor sampled.
        while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
            check({tag, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
            bus.din         = WIDTH'($urandom);
            bus.select      = 1'($urandom_range(0, 1));
            bus.direction   = 1'($urandom_range(0, 1));
            bus.shift_value = SHW'($urandom_range(0, WIDTH - 1));
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(int'(sv) + 1));
        exp_v = exp_q.pop_front();
        check({tag, "_dout"}, 32'(bus.dout), 32'(exp_v[WIDTH:1]));
        check({tag, "_exact"}, 32'(bus.exact), 32'(exp_v[0]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_hold_dout"}, 32'(bus.dout), 32'(exp_v[WIDTH:1]));
            check({tag, "_hold_exact"}, 32'(bus.exact), 32'(exp_v[0]));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_drained_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_drained_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic               r_sel;
        logic               r_dir;
        logic [SHW-1:0]     r_sv;
        logic [WIDTH-1:0]   r_din;

        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.select      = 1'b0;
        bus.direction   = 1'b0;
        bus.shift_value = '0;
        bus.din         = '0;
        bus.out_ready   = 1'b0;

        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_exact", 32'(bus.exact), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        do_op("rot_r1", OP_ROTATE, DIR_RIGHT, 2'd1, 4'b1101, {4'b1011, 1'b1}, 0);
        do_op("rot_l3", OP_ROTATE, DIR_LEFT, 2'd3, 4'b0110, {4'b1100, 1'b1}, 0);
        do_op("shf_ok", OP_SHIFT, DIR_RIGHT, 2'd2, 4'b0010, {4'b1000, 1'b1}, 0);
        do_op("shf_bad_r", OP_SHIFT, DIR_RIGHT, 2'd2, 4'b0110, {4'b1000, 1'b0}, 0);
        do_op("shf_bad_l", OP_SHIFT, DIR_LEFT, 2'd1, 4'b0101, {4'b0010, 1'b0}, 0);
        do_op("zero_bp", OP_SHIFT, DIR_RIGHT, 2'd0, 4'b1001, {4'b1001, 1'b1}, 3);

        // Abort during the second RUN cycle.
        bus.select      = OP_ROTATE;
        bus.direction   = DIR_RIGHT;
        bus.shift_value = 2'd3;
        bus.din         = 4'b1110;
        bus.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_in_run", 32'(dbg_state), 32'(RUN));
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_dout", 32'(bus.dout), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        do_op("post_rst_rot", OP_ROTATE, DIR_RIGHT, 2'd1, 4'b1101, {4'b1011, 1'b1}, 0);

        for (int n = 0; n < 10; n++) begin
            r_sel = 1'($urandom_range(0, 1));
            r_dir = 1'($urandom_range(0, 1));
            r_sv  = SHW'($urandom_range(0, WIDTH - 1));
            r_din = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            do_op($sformatf("rnd%0d", n), r_sel, r_dir, r_sv, r_din,
                  model(r_sel, r_dir, r_sv, r_din), $urandom_range(0, 2));
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_unshifter_seq.md
Name: barrel_unshifter_seq

Overview:
- Sequential inverse of the team's 4-bit barrel shifter (the decode end of the shift/rotate datapath).
- Takes a word that the forward shifter has already processed, plus the same select/direction/shift_value controls, and recovers the original word.
- Rotates are reversed exactly. Shifts are reversed with zero fill, and an `exact` flag reports whether the input is a word the forward shifter could actually have produced.
- Iterative: moves one bit position per clock, with valid/ready handshakes on both input and output. It sits after the shifter in loopback/self-check paths.

Parameters:
- WIDTH, 4, data width in bits; legal range is 2 or more.
- SHW, $clog2(WIDTH), width of shift_value; derived, do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (high only in IDLE).
- select  input  1  operation the forward shifter applied: 0 = shift, 1 = rotate.
- direction  input  1  direction the forward shifter moved bits: 0 = right, 1 = left.
- shift_value  input  SHW  forward shift amount, 0..WIDTH-1.
- din  input  WIDTH  encoded word (the forward shifter's output).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- dout  output  WIDTH  recovered word.
- exact  output  1  1 = recovery is lossless/consistent; 0 = forward shift dropped nonzero bits.

Behaviour:
- Reset (async assert, any state): state=IDLE, work register=0, counter=0, dout=0, exact=0, out_valid=0. in_ready is 1 once reset deasserts.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE->RUN on in_valid&&in_ready with shift_value!=0. On that edge:
  - work<=din, cnt<=shift_value, exact<=1.
  - Latch select and direction.
- IDLE->DONE on accept with shift_value==0: work<=din, exact<=1.
- RUN step, once per cycle, applying the opposite direction of the forward operation by 1 bit:
  - direction=0 (forward right, so step left): work<={work[W-2:0], fill}, with fill = select ? work[W-1] : 0.
  - direction=1 (forward left, so step right): work<={fill, work[W-1:1]}, with fill = select ? work[0] : 0.
  - Shift mode (select=0): if the bit shifted out is 1, exact<=0 (sticky). Rotate mode never clears exact.
  - cnt<=cnt-1; when cnt==1 on a step, RUN->DONE.
- DONE->IDLE on out_ready. dout, exact and out_valid hold stable while out_ready=0.
- dout=work and is valid whenever out_valid=1. Outside DONE its value is don't-care for the checker.
- Latency: out_valid rises shift_value+1 cycles after the accepting edge. Throughput is one op per shift_value+2 cycles minimum.
- in_valid while busy is ignored and not queued. Input ports are sampled only on the accept edge; changes during RUN have no effect.
- shift_value=WIDTH-1 is the maximum; no wrap issues because cnt is SHW bits.
- Reset mid-RUN or mid-DONE aborts the op and the result is discarded. The first op after reset behaves normally.

Decomposition:
- Package barrel_pkg:
  - Enum state_t {IDLE, RUN, DONE}.
  - Constants OP_SHIFT=1'b0, OP_ROTATE=1'b1, DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
  - Shared by the forward shifter bench and this block.
- One combinational sub-module, barrel_step:
  - Inputs: WIDTH-bit word, select, step_left.
  - Outputs: next word and the shifted-out bit.
  - Instantiated once in the RUN datapath.
- FSM, counter and handshake stay in the top.

Test Plan:
- Rotate reverse: din=4'b1101, select=1, direction=0, shift_value=1 -> dout=4'b1011, exact=1, out_valid 2 cycles after accept.
- Rotate left 3 reverse: din=4'b0110, select=1, direction=1, shift_value=3 -> dout=4'b1100, exact=1, out_valid 4 cycles after accept.
- Consistent shift: din=4'b0010, select=0, direction=0, shift_value=2 -> dout=4'b1000, exact=1.
- Inconsistent shift: din=4'b0110, select=0, direction=0, shift_value=2 -> dout=4'b1000, exact=0. Also din=4'b0101, select=0, direction=1, shift_value=1 -> dout=4'b0010, exact=0.
- Zero shift plus backpressure: din=4'b1001, shift_value=0, out_ready=0 for 3 cycles -> out_valid 1 cycle after accept, dout=4'b1001 stable, in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op: din=4'b1110, select=1, shift_value=3, rst_n low during the 2nd RUN cycle -> out_valid=0 and dout=0 immediately, in_ready=1 after release. Follow with the first rotate-reverse test -> identical result and latency.
